// File: rtl/score_combo_tracker.sv
// Score/combo tracker: captures catch/miss edges from NUM_OBJ object channels
// and services them one at a time, adding points through a digit-serial BCD adder.
module score_combo_tracker #(
  parameter int NUM_OBJ    = 4,
  parameter int COMBO_STEP = 5,
  parameter int MULT_MAX   = 4
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 clear,
  input  logic [4*NUM_OBJ-1:0] points,
  input  logic [NUM_OBJ-1:0]   point_mux,
  input  logic [NUM_OBJ-1:0]   combo_reset,
  output logic [15:0]          score_bcd,
  output logic [7:0]           combo_bcd,
  output logic [2:0]           multiplier,
  output logic [15:0]          high_score_bcd,
  output logic                 new_high,
  output logic                 catch_pulse,
  output logic                 busy
);

  // state | meaning
  // IDLE  | waiting; picks lowest pending channel, tracks high score
  // PT    | bump combo, compute multiplier and BCD amount, load working score
  // ADD   | one BCD digit per cycle into working score, commit after digit 3
  // CR    | miss: combo back to 0, multiplier back to 1
  typedef enum logic [1:0] {S_IDLE, S_PT, S_ADD, S_CR} state_t;

  localparam int CW = (NUM_OBJ > 1) ? $clog2(NUM_OBJ) : 1;

  state_t               state_q, state_d;
  logic [CW-1:0]        ch_q, ch_d;
  logic [1:0]           dig_q, dig_d;
  logic                 carry_q, carry_d;
  logic [15:0]          work_q, work_d;
  logic [7:0]           amount_q, amount_d;
  logic [15:0]          score_q, score_d;
  logic [7:0]           combo_q, combo_d;
  logic [2:0]           mult_q, mult_d;
  logic [15:0]          high_q, high_d;
  logic                 new_high_q, new_high_d;
  logic                 nh_done_q, nh_done_d;
  logic                 catch_q, catch_d;
  logic [NUM_OBJ-1:0]   pm_q, cr_q;
  logic [NUM_OBJ-1:0]   pend_pt_q, pend_pt_d;
  logic [NUM_OBJ-1:0]   pend_cr_q, pend_cr_d;
  logic [3:0]           pts_lat_q [NUM_OBJ];
  logic [3:0]           pts_lat_d [NUM_OBJ];

  logic [NUM_OBJ-1:0]   pt_edge, cr_edge;
  logic                 any_pend;
  logic [CW-1:0]        sel;
  logic [7:0]           combo_inc;
  logic [6:0]           combo_bin;
  logic [6:0]           mult_raw;
  logic [2:0]           mult_new;
  logic [6:0]           prod;
  logic [7:0]           amount_bcd;
  logic [3:0]           dig_a, dig_b, dig_sum;
  logic [4:0]           dig_raw;
  logic                 dig_cy;

  assign pt_edge  = point_mux & ~pm_q;
  assign cr_edge  = combo_reset & ~cr_q;
  assign any_pend = |(pend_pt_q | pend_cr_q);

  always_comb begin
    sel = '0;
    for (int i = NUM_OBJ - 1; i >= 0; i--) begin
      if (pend_pt_q[i] | pend_cr_q[i]) sel = CW'(i);
    end
  end

  // Combo increment (saturating at 99) and the multiplier it implies.
  always_comb begin
    if (combo_q == 8'h99)
      combo_inc = combo_q;
    else if (combo_q[3:0] == 4'd9)
      combo_inc = {combo_q[7:4] + 4'd1, 4'd0};
    else
      combo_inc = {combo_q[7:4], combo_q[3:0] + 4'd1};
    combo_bin = 7'(combo_inc[7:4]) * 7'd10 + 7'(combo_inc[3:0]);
    mult_raw  = combo_bin / 7'(COMBO_STEP) + 7'd1;
    mult_new  = (mult_raw > 7'(MULT_MAX)) ? 3'(MULT_MAX) : 3'(mult_raw);
    prod      = 7'(pts_lat_q[ch_q]) * 7'(mult_new);
    amount_bcd = {4'(prod / 7'd10), 4'(prod % 7'd10)};
  end

  always_comb begin
    dig_a = work_q[{dig_q, 2'b00} +: 4];
    unique case (dig_q)
      2'd0:    dig_b = amount_q[3:0];
      2'd1:    dig_b = amount_q[7:4];
      default: dig_b = 4'd0;
    endcase
    dig_raw = {1'b0, dig_a} + {1'b0, dig_b} + {4'b0, carry_q};
    if (dig_raw > 5'd9) begin
      dig_sum = 4'(dig_raw - 5'd10);
      dig_cy  = 1'b1;
    end else begin
      dig_sum = dig_raw[3:0];
      dig_cy  = 1'b0;
    end
  end

  always_comb begin
    state_d    = state_q;
    ch_d       = ch_q;
    dig_d      = dig_q;
    carry_d    = carry_q;
    work_d     = work_q;
    amount_d   = amount_q;
    score_d    = score_q;
    combo_d    = combo_q;
    mult_d     = mult_q;
    high_d     = high_q;
    new_high_d = 1'b0;
    nh_done_d  = nh_done_q;
    catch_d    = 1'b0;
    pend_pt_d  = pend_pt_q;
    pend_cr_d  = pend_cr_q;
    pts_lat_d  = pts_lat_q;

    unique case (state_q)
      S_IDLE: begin
        if (score_q > high_q) begin
          high_d = score_q;
          if (!nh_done_q) begin
            new_high_d = 1'b1;
            nh_done_d  = 1'b1;
          end
        end
        if (any_pend) begin
          ch_d    = sel;
          state_d = pend_pt_q[sel] ? S_PT : S_CR;
        end
      end
      S_PT: begin
        combo_d   = combo_inc;
        mult_d    = mult_new;
        amount_d  = amount_bcd;
        work_d    = score_q;
        carry_d   = 1'b0;
        dig_d     = 2'd0;
        pend_pt_d[ch_q] = 1'b0;
        state_d   = S_ADD;
      end
      S_ADD: begin
        work_d[{dig_q, 2'b00} +: 4] = dig_sum;
        carry_d = dig_cy;
        dig_d   = dig_q + 2'd1;
        if (dig_q == 2'd3) begin
          score_d = dig_cy ? 16'h9999 : work_d;
          catch_d = 1'b1;
          state_d = pend_cr_q[ch_q] ? S_CR : S_IDLE;
        end
      end
      S_CR: begin
        combo_d = 8'h00;
        mult_d  = 3'd1;
        pend_cr_d[ch_q] = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // New edges land after the service clear so an edge in the clearing cycle is kept.
    pend_pt_d = pend_pt_d | pt_edge;
    pend_cr_d = pend_cr_d | cr_edge;
    for (int i = 0; i < NUM_OBJ; i++) begin
      if (pt_edge[i]) pts_lat_d[i] = points[4*i +: 4];
    end

    if (clear) begin
      state_d    = S_IDLE;
      score_d    = 16'h0000;
      combo_d    = 8'h00;
      mult_d     = 3'd1;
      pend_pt_d  = '0;
      pend_cr_d  = '0;
      nh_done_d  = 1'b0;
      new_high_d = 1'b0;
      catch_d    = 1'b0;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q    <= S_IDLE;
      ch_q       <= '0;
      dig_q      <= 2'd0;
      carry_q    <= 1'b0;
      work_q     <= 16'h0000;
      amount_q   <= 8'h00;
      score_q    <= 16'h0000;
      combo_q    <= 8'h00;
      mult_q     <= 3'd1;
      high_q     <= 16'h0000;
      new_high_q <= 1'b0;
      nh_done_q  <= 1'b0;
      catch_q    <= 1'b0;
      pm_q       <= '0;
      cr_q       <= '0;
      pend_pt_q  <= '0;
      pend_cr_q  <= '0;
      for (int i = 0; i < NUM_OBJ; i++) pts_lat_q[i] <= 4'd0;
    end else begin
      state_q    <= state_d;
      ch_q       <= ch_d;
      dig_q      <= dig_d;
      carry_q    <= carry_d;
      work_q     <= work_d;
      amount_q   <= amount_d;
      score_q    <= score_d;
      combo_q    <= combo_d;
      mult_q     <= mult_d;
      high_q     <= high_d;
      new_high_q <= new_high_d;
      nh_done_q  <= nh_done_d;
      catch_q    <= catch_d;
      pm_q       <= point_mux;
      cr_q       <= combo_reset;
      pend_pt_q  <= pend_pt_d;
      pend_cr_q  <= pend_cr_d;
      pts_lat_q  <= pts_lat_d;
    end
  end

  assign score_bcd      = score_q;
  assign combo_bcd      = combo_q;
  assign multiplier     = mult_q;
  assign high_score_bcd = high_q;
  assign new_high       = new_high_q;
  assign catch_pulse    = catch_q;
  assign busy           = (state_q != S_IDLE);

endmodule

// File: tb/tb_score_combo_tracker.sv
// Bench for score_combo_tracker: directed scenarios plus random event bursts,
// each checked against a transaction-level model of score, combo and high score.
module tb_score_combo_tracker;

  logic        Clk = 1'b0;
  logic        Reset, clear;
  logic [15:0] points;
  logic [3:0]  point_mux, combo_reset;
  logic [15:0] score_bcd, high_score_bcd;
  logic [7:0]  combo_bcd;
  logic [2:0]  multiplier;
  logic        new_high, catch_pulse, busy;

  score_combo_tracker dut (
    .Clk(Clk), .Reset(Reset), .clear(clear), .points(points),
    .point_mux(point_mux), .combo_reset(combo_reset),
    .score_bcd(score_bcd), .combo_bcd(combo_bcd), .multiplier(multiplier),
    .high_score_bcd(high_score_bcd), .new_high(new_high),
    .catch_pulse(catch_pulse), .busy(busy)
  );

  always #10 Clk = ~Clk;

  int n_tests = 0, n_fail = 0;
  int cyc_cnt = 0, mon_catch = 0, mon_nh = 0, last_pulse = 0, prev_pulse = 0;
  int m_score, m_combo, m_high, exp_catch = 0, exp_nh = 0;
  bit m_nh_seen;

  always @(posedge Clk) cyc_cnt++;
  always @(negedge Clk) begin
    if (catch_pulse === 1'b1) begin
      mon_catch++;
      prev_pulse = last_pulse;
      last_pulse = cyc_cnt;
    end
    if (new_high === 1'b1) mon_nh++;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int to_bcd(input int v);
    return ((v / 1000) % 10) * 4096 + ((v / 100) % 10) * 256 + ((v / 10) % 10) * 16 + v % 10;
  endfunction

  function automatic int m_mult();
    int m;
    m = 1 + m_combo / 5;
    return (m > 4) ? 4 : m;
  endfunction

  task automatic model_clear();
    m_score = 0; m_combo = 0; m_nh_seen = 0;
  endtask

  task automatic model_reset();
    model_clear();
    m_high = 0;
  endtask

  // Channels in ascending order; per channel the catch is scored before the miss.
  task automatic model_events(input logic [3:0] pm, input logic [3:0] cr, input logic [15:0] pts);
    for (int i = 0; i < 4; i++) begin
      if (pm[i]) begin
        if (m_combo < 99) m_combo++;
        m_score += int'(pts[4*i +: 4]) * m_mult();
        if (m_score > 9999) m_score = 9999;
        exp_catch++;
      end
      if (cr[i]) m_combo = 0;
    end
    if (m_score > m_high) begin
      m_high = m_score;
      if (!m_nh_seen) begin
        exp_nh++;
        m_nh_seen = 1;
      end
    end
  endtask

  task automatic check_state(input string tag);
    check_val({tag, ":score"}, score_bcd, to_bcd(m_score));
    check_val({tag, ":combo"}, combo_bcd, to_bcd(m_combo));
    check_val({tag, ":mult"}, multiplier, m_mult());
    check_val({tag, ":high"}, high_score_bcd, to_bcd(m_high));
    check_val({tag, ":catches"}, mon_catch, exp_catch);
    check_val({tag, ":new_high"}, mon_nh, exp_nh);
  endtask

  task automatic wait_idle(input string tag);
    int idle = 0, cyc = 0;
    while (idle < 3 && cyc < 500) begin
      @(posedge Clk); #1;
      cyc++;
      idle = busy ? 0 : idle + 1;
    end
    check_val({tag, ":idle_reached"}, idle >= 3, 1);
  endtask

  task automatic do_reset();
    Reset = 1; clear = 0; point_mux = 0; combo_reset = 0; points = 0;
    repeat (3) @(posedge Clk);
    #1 Reset = 0;
    model_reset();
  endtask

  task automatic do_clear();
    clear = 1;
    @(posedge Clk); #1;
    clear = 0;
    model_clear();
  endtask

  task automatic trial(input string tag, input logic [3:0] pm, input logic [3:0] cr,
                       input logic [15:0] pts, input bit hold_cr);
    point_mux = 0; combo_reset = 0;
    @(posedge Clk); #1;
    points = pts; point_mux = pm; combo_reset = cr;
    @(posedge Clk); #1;
    point_mux = 0;
    points = 16'($urandom);
    if (!hold_cr) combo_reset = 0;
    model_events(pm, cr, pts);
    wait_idle(tag);
    check_state(tag);
  endtask

  initial begin
    int n, r, busy_cnt;
    logic [3:0] pm, cr;
    do_reset();
    check_val("rst:score", score_bcd, 16'h0000);
    check_val("rst:combo", combo_bcd, 8'h00);
    check_val("rst:mult", multiplier, 3'd1);
    check_val("rst:high", high_score_bcd, 16'h0000);
    check_val("rst:pulses", {new_high, catch_pulse, busy}, 3'b000);

    // Single ch0 catch: latency from input rise to catch/score update.
    @(posedge Clk); #1;
    points = 16'h0003; point_mux = 4'b0001;
    n = 0;
    while (catch_pulse !== 1'b1 && n < 20) begin
      @(posedge Clk); #1;
      n++;
      point_mux = 0;
      points = 16'($urandom);
    end
    model_events(4'b0001, 4'b0000, 16'h0003);
    check_val("lat:cycles", n, 7);
    check_val("lat:score", score_bcd, 16'h0003);
    check_val("lat:combo", combo_bcd, 8'h01);
    check_val("lat:busy", busy, 1'b0);
    @(posedge Clk); #1;
    check_val("lat:pulse_width", catch_pulse, 1'b0);
    wait_idle("lat");
    check_state("lat");

    do_clear();
    for (int i = 0; i < 5; i++) trial("five_ch1", 4'b0010, 4'b0000, 16'h0020, 0);
    check_val("five_ch1:mult2", multiplier, 3'd2);

    trial("to7", 4'b0010, 4'b0000, 16'h0020, 0);
    trial("to7", 4'b0010, 4'b0000, 16'h0020, 0);
    trial("cr_hold", 4'b0000, 4'b0100, 16'h0000, 1);
    busy_cnt = 0;
    for (int i = 0; i < 1000; i++) begin
      @(posedge Clk); #1;
      if (busy) busy_cnt++;
    end
    check_val("cr_hold:busy", busy_cnt, 0);
    check_state("cr_hold");
    trial("after_cr", 4'b0001, 4'b0000, 16'h0001, 0);

    trial("ch0_ch3", 4'b1001, 4'b0000, 16'h3001, 0);
    check_val("ch0_ch3:gap", last_pulse - prev_pulse, 6);

    // Saturation: catch+miss pairs add points at multiplier 1 exactly.
    do_clear();
    while (9995 - m_score >= 15) trial("sat_fill", 4'b0001, 4'b0001, 16'h000F, 0);
    r = 9995 - m_score;
    if (r > 0) trial("sat_fill", 4'b0001, 4'b0001, 16'(r), 0);
    check_val("sat:preload", score_bcd, 16'h9995);
    trial("sat", 4'b0001, 4'b0001, 16'h000C, 0);
    check_val("sat:score", score_bcd, 16'h9999);

    do_clear();
    for (int i = 0; i < 25; i++) trial("combo99", 4'b1111, 4'b0000, 16'h1111, 0);
    check_val("combo99:combo", combo_bcd, 8'h99);

    // High score across games.
    do_reset();
    trial("hs_g1", 4'b0001, 4'b0001, 16'h000F, 0);
    trial("hs_g1", 4'b0001, 4'b0001, 16'h000F, 0);
    do_clear();
    trial("hs_g2", 4'b0001, 4'b0001, 16'h000F, 0);
    trial("hs_g2", 4'b0001, 4'b0001, 16'h000F, 0);
    trial("hs_g2", 4'b0001, 4'b0001, 16'h000C, 0);
    check_val("hs:high42", high_score_bcd, 16'h0042);
    do_clear();
    wait_idle("hs_clr");
    check_state("hs_clr");
    do_reset();
    check_val("hs:reset_high", high_score_bcd, 16'h0000);

    // Clear mid-operation and clear coinciding with an edge.
    trial("pre_abort", 4'b0100, 4'b0000, 16'h0700, 0);
    @(posedge Clk); #1;
    points = 16'h0090; point_mux = 4'b0010;
    @(posedge Clk); #1;
    point_mux = 0;
    repeat (3) @(posedge Clk);
    #1 clear = 1;
    @(posedge Clk); #1;
    clear = 0;
    model_clear();
    check_val("abort:busy", busy, 1'b0);
    check_val("abort:score", score_bcd, 16'h0000);
    repeat (10) @(posedge Clk);
    #1;
    check_state("abort");
    points = 16'h0F00; point_mux = 4'b0100; clear = 1;
    @(posedge Clk); #1;
    clear = 0; point_mux = 0;
    model_clear();
    wait_idle("clr_edge");
    check_state("clr_edge");

    for (int t = 0; t < 200; t++) begin
      if ($urandom_range(0, 19) == 0) do_clear();
      pm = 4'($urandom);
      cr = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
      trial("rand", pm, cr, 16'($urandom), 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
